hit_detector: RTL and testbench

//  Producer side of the score "hit" interface. Once per frame, snapshots the bullet and all asteroid

---
 rtl/asteroids_pkg.sv | 28 ++
 rtl/box_overlap.sv | 43 ++++
 rtl/hit_detector.sv | 170 +++++++++++++++++
 tb/tb_hit_detector.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/asteroids_pkg.sv
// Purpose : shared types and default sizes for the asteroid game datapath blocks.
// Contents: scan FSM state encoding, default object/screen dimensions, index-width helper.
// Used by : hit_detector, box_overlap.
package asteroids_pkg;

   localparam int N_AST_DEF  = 4;
   localparam int X_W_DEF    = 8;
   localparam int Y_W_DEF    = 7;
   localparam int AST_SZ_DEF = 8;
   localparam int BUL_SZ_DEF = 2;

   // Screen extents implied by the default coordinate widths.
   localparam int SCREEN_W = 1 << X_W_DEF;
   localparam int SCREEN_H = 1 << Y_W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HIT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Width of a slot index; a single slot still needs one bit to carry it.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/box_overlap.sv
// Purpose : combinational 2-D box intersection test (asteroid box vs bullet box).
// Latency : 0 cycles, pure combinational. Backpressure: none.
// Ports   : ax/ay asteroid top-left, bx/by bullet top-left, overlap=1 when the boxes share a pixel.
module box_overlap
   import asteroids_pkg::*;
#(
   parameter int X_W  = X_W_DEF,
   parameter int Y_W  = Y_W_DEF,
   parameter int A_SZ = AST_SZ_DEF,
   parameter int B_SZ = BUL_SZ_DEF
) (
   input  logic [X_W-1:0] ax,
   input  logic [Y_W-1:0] ay,
   input  logic [X_W-1:0] bx,
   input  logic [Y_W-1:0] by,
   output logic           overlap
);

   // One extra bit so box far edges near the screen limit never wrap to 0.
   typedef logic [X_W:0] xe_t;
   typedef logic [Y_W:0] ye_t;

   localparam xe_t AX_OFF = xe_t'(A_SZ - 1);
   localparam xe_t BX_OFF = xe_t'(B_SZ - 1);
   localparam ye_t AY_OFF = ye_t'(A_SZ - 1);
   localparam ye_t BY_OFF = ye_t'(B_SZ - 1);

   xe_t ax_e, bx_e;
   ye_t ay_e, by_e;
   logic x_ok, y_ok;

   assign ax_e = {1'b0, ax};
   assign bx_e = {1'b0, bx};
   assign ay_e = {1'b0, ay};
   assign by_e = {1'b0, by};

   // Inclusive comparisons: boxes whose edges touch count as overlapping.
   assign x_ok = (bx_e <= ax_e + AX_OFF) && (ax_e <= bx_e + BX_OFF);
   assign y_ok = (by_e <= ay_e + AY_OFF) && (ay_e <= by_e + BY_OFF);

   assign overlap = x_ok && y_ok;

endmodule

// File: rtl/hit_detector.sv
// Purpose : per-frame bullet/asteroid collision scan; emits one hit pulse to the score block.
// Latency : slot k overlap -> hit in cycle k+2 after the frame_tick edge; done one cycle later.
// Backpr. : none; a frame_tick arriving mid-scan is dropped and flagged by sticky overrun.
// Ports   : clk, reset (sync, high); frame_tick, bullet_valid/x/y, ast_alive/x/y in;
//           hit, hit_idx, kill_ast, bullet_kill, busy, done, overrun out (all registered).
module hit_detector
   import asteroids_pkg::*;
#(
   parameter int N_AST  = N_AST_DEF,
   parameter int X_W    = X_W_DEF,
   parameter int Y_W    = Y_W_DEF,
   parameter int AST_SZ = AST_SZ_DEF,
   parameter int BUL_SZ = BUL_SZ_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          frame_tick,
   input  logic                          bullet_valid,
   input  logic [X_W-1:0]                bullet_x,
   input  logic [Y_W-1:0]                bullet_y,
   input  logic [N_AST-1:0]              ast_alive,
   input  logic [N_AST*X_W-1:0]          ast_x,
   input  logic [N_AST*Y_W-1:0]          ast_y,
   output logic                          hit,
   output logic [idx_width(N_AST)-1:0]   hit_idx,
   output logic [N_AST-1:0]              kill_ast,
   output logic                          bullet_kill,
   output logic                          busy,
   output logic                          done,
   output logic                          overrun
);

   localparam int IDX_W = idx_width(N_AST);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_AST - 1);

   state_t state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;

   // Frame snapshot: the scan works only on these, never on the live inputs.
   logic [X_W-1:0]       snap_bx, snap_bx_nxt;
   logic [Y_W-1:0]       snap_by, snap_by_nxt;
   logic [N_AST-1:0]     snap_alive, snap_alive_nxt;
   logic [N_AST*X_W-1:0] snap_ax, snap_ax_nxt;
   logic [N_AST*Y_W-1:0] snap_ay, snap_ay_nxt;

   logic                 hit_nxt, bullet_kill_nxt, busy_nxt, done_nxt, overrun_nxt;
   logic [IDX_W-1:0]     hit_idx_nxt;
   logic [N_AST-1:0]     kill_ast_nxt;

   logic [X_W-1:0] sel_ax;
   logic [Y_W-1:0] sel_ay;
   logic           sel_overlap;

   // Single comparator shared across slots; idx picks which slot it sees.
   assign sel_ax = snap_ax[idx*X_W +: X_W];
   assign sel_ay = snap_ay[idx*Y_W +: Y_W];

   box_overlap #(
      .X_W  (X_W),
      .Y_W  (Y_W),
      .A_SZ (AST_SZ),
      .B_SZ (BUL_SZ)
   ) u_box_overlap (
      .ax      (sel_ax),
      .ay      (sel_ay),
      .bx      (snap_bx),
      .by      (snap_by),
      .overlap (sel_overlap)
   );

   always_comb begin
      state_nxt       = state;
      idx_nxt         = idx;
      snap_bx_nxt     = snap_bx;
      snap_by_nxt     = snap_by;
      snap_alive_nxt  = snap_alive;
      snap_ax_nxt     = snap_ax;
      snap_ay_nxt     = snap_ay;
      hit_nxt         = 1'b0;
      hit_idx_nxt     = hit_idx;
      kill_ast_nxt    = '0;
      bullet_kill_nxt = 1'b0;
      busy_nxt        = busy;
      done_nxt        = 1'b0;
      overrun_nxt     = overrun | (frame_tick && (state != ST_IDLE));

      case (state)
         ST_IDLE: begin
            if (frame_tick) begin
               snap_bx_nxt    = bullet_x;
               snap_by_nxt    = bullet_y;
               snap_alive_nxt = ast_alive;
               snap_ax_nxt    = ast_x;
               snap_ay_nxt    = ast_y;
               idx_nxt        = '0;
               busy_nxt       = 1'b1;
               if (bullet_valid) begin
                  state_nxt = ST_SCAN;
               end else begin
                  // No bullet: nothing can hit, close the frame immediately.
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
               end
            end
         end
         ST_SCAN: begin
            // Scanning upward and stopping on the first hit makes the lowest slot win.
            if (snap_alive[idx] && sel_overlap) begin
               state_nxt       = ST_HIT;
               hit_nxt         = 1'b1;
               hit_idx_nxt     = idx;
               kill_ast_nxt    = N_AST'(1) << idx;
               bullet_kill_nxt = 1'b1;
            end else if (idx == LAST_IDX) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         ST_HIT: begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         snap_bx     <= '0;
         snap_by     <= '0;
         snap_alive  <= '0;
         snap_ax     <= '0;
         snap_ay     <= '0;
         hit         <= 1'b0;
         hit_idx     <= '0;
         kill_ast    <= '0;
         bullet_kill <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         snap_bx     <= snap_bx_nxt;
         snap_by     <= snap_by_nxt;
         snap_alive  <= snap_alive_nxt;
         snap_ax     <= snap_ax_nxt;
         snap_ay     <= snap_ay_nxt;
         hit         <= hit_nxt;
         hit_idx     <= hit_idx_nxt;
         kill_ast    <= kill_ast_nxt;
         bullet_kill <= bullet_kill_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         overrun     <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_hit_detector.sv
// Purpose : directed self-checking bench for hit_detector with default parameters.
// Timing  : inputs driven and outputs sampled on the falling edge; "cycle c" is the
//           c-th falling edge after the posedge that sampled frame_tick.
module tb_hit_detector;
   import asteroids_pkg::*;

   localparam int N  = N_AST_DEF;
   localparam int XW = X_W_DEF;
   localparam int YW = Y_W_DEF;
   localparam int FAR_X = SCREEN_W - 56;   // 200
   localparam int FAR_Y = SCREEN_H - 28;   // 100

   logic               clk = 1'b0;
   logic               reset;
   logic               frame_tick;
   logic               bullet_valid;
   logic [XW-1:0]      bullet_x;
   logic [YW-1:0]      bullet_y;
   logic [N-1:0]       ast_alive;
   logic [N*XW-1:0]    ast_x;
   logic [N*YW-1:0]    ast_y;
   logic               hit;
   logic [1:0]         hit_idx;
   logic [N-1:0]       kill_ast;
   logic               bullet_kill;
   logic               busy;
   logic               done;
   logic               overrun;

   int errors = 0;
   int checks = 0;
   int hits_seen;

   hit_detector dut (
      .clk          (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .bullet_valid (bullet_valid),
      .bullet_x     (bullet_x),
      .bullet_y     (bullet_y),
      .ast_alive    (ast_alive),
      .ast_x        (ast_x),
      .ast_y        (ast_y),
      .hit          (hit),
      .hit_idx      (hit_idx),
      .kill_ast     (kill_ast),
      .bullet_kill  (bullet_kill),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ast(input int i, input int x, input int y, input logic alive);
      ast_x[i*XW +: XW] = XW'(x);
      ast_y[i*YW +: YW] = YW'(y);
      ast_alive[i]      = alive;
   endtask

   task automatic all_far();
      for (int i = 0; i < N; i++) set_ast(i, FAR_X, FAR_Y, 1'b1);
   endtask

   // Pulse frame_tick across one posedge; returns at the falling edge of cycle 1.
   task automatic start_scan();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   // Let any scan finish so the next test starts in IDLE.
   task automatic settle();
      for (int i = 0; i < 8; i++) step();
   endtask

   initial begin
      reset        = 1'b1;
      frame_tick   = 1'b1;
      bullet_valid = 1'b1;
      bullet_x     = '0;
      bullet_y     = '0;
      ast_alive    = '0;
      ast_x        = '0;
      ast_y        = '0;

      // 1. Reset held 3 cycles with frame_tick high.
      @(negedge clk);
      step(); step(); step();
      check("rst_hit",     {31'd0, hit},         32'd0);
      check("rst_hit_idx", {30'd0, hit_idx},     32'd0);
      check("rst_kill",    {28'd0, kill_ast},    32'd0);
      check("rst_bkill",   {31'd0, bullet_kill}, 32'd0);
      check("rst_busy",    {31'd0, busy},        32'd0);
      check("rst_done",    {31'd0, done},        32'd0);
      check("rst_overrun", {31'd0, overrun},     32'd0);
      reset      = 1'b0;
      frame_tick = 1'b0;
      step();

      // 2. Single overlap on slot 1.
      all_far();
      set_ast(1, 48, 36, 1'b1);
      bullet_x = 8'd50; bullet_y = 7'd40;
      start_scan();
      check("t2_c1_hit",  {31'd0, hit},  32'd0);
      check("t2_c1_busy", {31'd0, busy}, 32'd1);
      step();
      check("t2_c2_hit",  {31'd0, hit},  32'd0);
      step();
      check("t2_c3_hit",   {31'd0, hit},         32'd1);
      check("t2_c3_idx",   {30'd0, hit_idx},     32'd1);
      check("t2_c3_kill",  {28'd0, kill_ast},    32'b0010);
      check("t2_c3_bkill", {31'd0, bullet_kill}, 32'd1);
      step();
      check("t2_c4_done", {31'd0, done}, 32'd1);
      check("t2_c4_hit",  {31'd0, hit},  32'd0);
      check("t2_c4_kill", {28'd0, kill_ast}, 32'd0);
      step();
      check("t2_c5_busy", {31'd0, busy}, 32'd0);
      check("t2_c5_idx_hold", {30'd0, hit_idx}, 32'd1);
      settle();

      // 3. Slots 0 and 2 both overlap: lowest wins, single pulse.
      all_far();
      set_ast(0, 48, 36, 1'b1);
      set_ast(2, 49, 38, 1'b1);
      start_scan();
      hits_seen = 0;
      if (hit) hits_seen++;
      step();
      check("t3_c2_hit",  {31'd0, hit},      32'd1);
      check("t3_c2_kill", {28'd0, kill_ast}, 32'b0001);
      check("t3_c2_idx",  {30'd0, hit_idx},  32'd0);
      if (hit) hits_seen++;
      for (int c = 3; c <= 8; c++) begin
         step();
         if (hit) hits_seen++;
      end
      check("t3_hit_count", hits_seen, 32'd1);
      settle();

      // 4a. Right edge touching: x=17 hits, x=18 misses.
      all_far();
      set_ast(0, 10, 10, 1'b1);
      bullet_x = 8'd17; bullet_y = 7'd10;
      start_scan();
      step();
      check("t4a_x17_hit", {31'd0, hit}, 32'd1);
      settle();
      bullet_x = 8'd18;
      start_scan();
      hits_seen = 0;
      for (int c = 1; c <= 4; c++) begin
         if (hit) hits_seen++;
         if (c == 4) check("t4a_x18_c4_done", {31'd0, done}, 32'd0);
         step();
      end
      check("t4a_x18_c5_done", {31'd0, done}, 32'd1);
      check("t4a_x18_nohit", hits_seen, 32'd0);
      settle();

      // 4b. Near max coordinates, slot 3: no wraparound miss.
      all_far();
      set_ast(3, 252, 120, 1'b1);
      bullet_x = 8'd254; bullet_y = 7'd126;
      start_scan();
      for (int c = 1; c < 5; c++) step();
      check("t4b_c5_hit",  {31'd0, hit},      32'd1);
      check("t4b_c5_idx",  {30'd0, hit_idx},  32'd3);
      check("t4b_c5_kill", {28'd0, kill_ast}, 32'b1000);
      settle();

      // 5a. Overlapping but dead asteroid never hits.
      all_far();
      set_ast(1, 48, 36, 1'b0);
      bullet_x = 8'd50; bullet_y = 7'd40;
      start_scan();
      hits_seen = 0;
      for (int c = 1; c <= 6; c++) begin
         if (hit) hits_seen++;
         step();
      end
      check("t5a_dead_nohit", hits_seen, 32'd0);
      settle();

      // 5b. No bullet: done in cycle 1, idle in cycle 2.
      set_ast(1, 48, 36, 1'b1);
      bullet_valid = 1'b0;
      start_scan();
      check("t5b_c1_done", {31'd0, done}, 32'd1);
      check("t5b_c1_busy", {31'd0, busy}, 32'd1);
      check("t5b_c1_hit",  {31'd0, hit},  32'd0);
      step();
      check("t5b_c2_busy", {31'd0, busy}, 32'd0);
      bullet_valid = 1'b1;
      settle();

      // 6a. frame_tick during scan: ignored, overrun sticks until reset.
      all_far();
      set_ast(2, 48, 36, 1'b1);
      start_scan();
      step();
      frame_tick = 1'b1;
      check("t6a_c2_overrun", {31'd0, overrun}, 32'd0);
      step();
      frame_tick = 1'b0;
      check("t6a_c3_overrun", {31'd0, overrun}, 32'd1);
      step();
      check("t6a_c4_hit", {31'd0, hit},     32'd1);
      check("t6a_c4_idx", {30'd0, hit_idx}, 32'd2);
      settle();
      check("t6a_idle_busy",    {31'd0, busy},    32'd0);
      check("t6a_sticky",       {31'd0, overrun}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6a_rst_overrun", {31'd0, overrun}, 32'd0);
      check("t6a_rst_idx",     {30'd0, hit_idx}, 32'd0);
      step();

      // 6b. Reset in cycle 2 with slot 3 overlapping: no hit ever appears.
      all_far();
      set_ast(3, 48, 36, 1'b1);
      start_scan();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6b_c3_busy", {31'd0, busy}, 32'd0);
      hits_seen = 0;
      for (int c = 3; c <= 8; c++) begin
         if (hit) hits_seen++;
         step();
      end
      check("t6b_nohit",    hits_seen, 32'd0);
      check("t6b_busy_end", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
